// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
//   DEFAULT_DATA_WIDTH : default frame length in bits
//   state_e            : responder FSM state encoding
//   BIT_CNT_W          : bit-counter width for the default frame length
//   bit_cnt_width()    : bit-counter width for an arbitrary frame length
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StWaitCs = 2'd2
    } state_e;

    // Counter must hold the value DATA_WIDTH itself, not just DATA_WIDTH-1.
    function automatic int unsigned bit_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned BIT_CNT_W = $clog2(DEFAULT_DATA_WIDTH + 1);

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with edge detection on the synchronized output.
//   clk     : system clock
//   reset   : asynchronous active-high reset; all flops load RESET_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized level (last synchronizer stage)
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
// SYNC_STAGES must be at least 2.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    // Copy of the last stage, one cycle older; edges compare the two.
    logic                   prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        q_o    = sync_q[SYNC_STAGES-1];
        rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

endmodule

// File: rtl/spi_slave.sv
// SPI responder: full duplex, DATA_WIDTH-bit frames, LSB first. The master
// drives MOSI on SCLK rising and samples MISO on SCLK falling; this block
// samples MOSI and advances MISO on the synchronized SCLK falling edge.
//   clk, reset          : system clock (>= 8x SCLK), async active-high reset
//   SCLK, CS, MOSI      : raw serial inputs from the master (CS active low)
//   MISO, misoEnable    : serial output and its tri-state enable
//   slaveDataToSend     : word for the next frame, captured on load
//   load                : one-cycle strobe into the holding register
//   slaveDataReceived   : last complete received word
//   rxValid             : one-cycle pulse when slaveDataReceived updates
//   busy                : high from frame start until CS deasserts
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  misoEnable,
    input  logic [DATA_WIDTH-1:0] slaveDataToSend,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] slaveDataReceived,
    output logic                  rxValid,
    output logic                  busy
);

    localparam int unsigned CntW = bit_cnt_width(DATA_WIDTH);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (SCLK),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // CS idles high, so its synchronizer resets high to avoid a false frame start.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (CS),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Same depth as SCLK so mosi_s is stable when sclk_fall is seen.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_mosi_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (MOSI),
        .q_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  frame_full;

    assign frame_full = (cnt_q == CntW'(DATA_WIDTH));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                // A full word is published even if CS rises in the same cycle.
                if (frame_full) begin
                    state_d = cs_rise ? StIdle : StWaitCs;
                end else if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StWaitCs: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        hold_d     = load ? slaveDataToSend : hold_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    // A load in the start cycle bypasses the holding register.
                    tx_d  = load ? slaveDataToSend : hold_q;
                    rx_d  = '0;
                    cnt_d = '0;
                end
            end
            StShift: begin
                if (frame_full) begin
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                end else if (cs_rise) begin
                    // Abort: partial word is simply dropped.
                    cnt_d = '0;
                end else if (sclk_fall) begin
                    rx_d  = {mosi_s, rx_q[DATA_WIDTH-1:1]};
                    tx_d  = {1'b0, tx_q[DATA_WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitCs: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Outputs: decoded from registered state, so they change only on clk.
    always_comb begin
        misoEnable        = (state_q != StIdle);
        busy              = (state_q != StIdle);
        MISO              = (state_q == StShift) ? tx_q[0] : 1'b0;
        slaveDataReceived = rx_data_q;
        rxValid           = rx_valid_q;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder that pairs with the team's SPI master: single-slave full-duplex, DATA_WIDTH-bit frames, LSB first.
- Master behaviour this block pairs with: drives MOSI on SCLK rising, samples MISO on SCLK falling, holds its CS bit low for the whole frame.
- This block runs on its own system clock. It synchronizes SCLK, CS and MOSI, detects SCLK edges, and exchanges one word per frame with local logic through a load/valid interface.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- SYNC_STAGES, 2, flip-flop stages on SCLK, CS and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; frequency must be at least 8x SCLK.
- reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  serial clock from the master.
- CS  input  1  chip select, active low (this slave's bit of the master's CS bus).
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- misoEnable  output  1  high while MISO is actively driven; the top level uses it as the tri-state enable.
- slaveDataToSend  input  DATA_WIDTH  word for the next frame.
- load  input  1  one-cycle strobe; captures slaveDataToSend into the holding register.
- slaveDataReceived  output  DATA_WIDTH  last complete received word.
- rxValid  output  1  one-cycle pulse when slaveDataReceived updates.
- busy  output  1  high from frame start until CS deasserts.

Behaviour:
- Reset values (asynchronous):
  - Outputs: MISO=0, misoEnable=0, slaveDataReceived=0, rxValid=0, busy=0.
  - Internal: holding, tx and rx shift registers = 0; bit counter = 0; synchronizer flops: SCLK=0, CS=1, MOSI=0; state=IDLE.
- Synchronization: SCLK, CS and MOSI each pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronized SCLK/CS samples. MOSI has identical delay to SCLK, so the sample is aligned.
- Holding register: load=1 captures slaveDataToSend in any state. A load during a frame affects only the next frame.
- FSM states: IDLE, SHIFT, WAIT_CS.
  - IDLE, CS falling detected:
    - tx shift <= holding register; if load is high in the same cycle, tx shift <= slaveDataToSend (load wins).
    - bit counter <= 0; misoEnable <= 1; busy <= 1; go to SHIFT.
    - MISO = tx shift bit 0 from the next clk cycle, before the master's first sample.
  - SHIFT, SCLK falling detected:
    - rx shift <= {MOSI_sync, rx[DATA_WIDTH-1:1]}; tx shift shifts right, filling with 0; bit counter increments.
    - MISO follows the new tx bit 0 within 1 clk cycle.
  - SHIFT, DATA_WIDTH-th falling edge: in the next cycle, slaveDataReceived <= completed rx word and rxValid pulses for exactly 1 cycle; go to WAIT_CS.
  - SHIFT, CS rising detected before DATA_WIDTH bits (abort): discard the partial word, no rxValid, slaveDataReceived unchanged; misoEnable <= 0, busy <= 0; go to IDLE.
  - WAIT_CS:
    - Further SCLK edges are ignored and MISO holds 0.
    - CS rising: misoEnable <= 0, busy <= 0; go to IDLE.
  - CS rising and an SCLK falling edge detected in the same cycle: CS wins (frame end or abort). A completing sample is not taken.
- Latency: rxValid asserts SYNC_STAGES+2 clk cycles after the raw SCLK falling edge of the final bit.
- Back-to-back frames: after returning to IDLE, a new CS falling edge is accepted in the very next cycle.
- Asynchronous reset mid-frame returns every register to its reset value immediately; the frame in progress is lost.
- SCLK edges while CS is high are ignored in IDLE.

Decomposition:
- Shared package spi_pkg holds:
  - DATA_WIDTH default constant;
  - state typedef/encoding: IDLE=2'd0, SHIFT=2'd1, WAIT_CS=2'd2;
  - bit-counter width constant, $clog2(DATA_WIDTH+1).
- One sub-module, spi_edge_sync: a SYNC_STAGES synchronizer with rise/fall pulse outputs and a parameterized reset value.
  - SCLK and CS use spi_edge_sync.
  - MOSI uses the same module with the edge outputs unused.

Test Plan:
- Reset: assert reset mid-idle -> all outputs 0 on the same cycle, MISO=0, misoEnable=0.
- Full duplex: load 8'h3C; master sends 8'hA5 at clk/8 SCLK -> MISO bits 0,0,1,1,1,1,0,0; slaveDataReceived=8'hA5; rxValid is a single pulse.
- Back-to-back frames: 8'h01 then 8'hFE with CS high for 2 SCLK periods -> two rxValid pulses; values 8'h01 then 8'hFE; second frame's MISO comes from a load made during the first frame.
- Abort: CS deasserted after 5 bits of 8'hFF -> no rxValid; slaveDataReceived keeps its previous value; next full frame of 8'h5A is received correctly.
- Load collision: load=1 with slaveDataToSend=8'h81 in the CS-falling detect cycle -> MISO shifts out 8'h81, not the old holding value.
- Reset mid-frame: assert reset after 3 bits -> busy=0, misoEnable=0 immediately; following clean frame of 8'hC3 received correctly.
